// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the chunked pipelined adder: operation mode
// encoding and the per-stage chunk width.
package adder_pkg;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

   function automatic int chunk_width(input int n, input int stages);
      return n / stages;
   endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle between a producer/consumer (master)
// and the pipelined adder (slave).
interface pipelined_adder_if #(
   parameter int N = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] input1;
   logic [N-1:0] input2;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] answer;
   logic         carry_out;
   logic         overflow;

   modport master (
      output in_valid, input1, input2, sub, out_ready,
      input  in_ready, out_valid, answer, carry_out, overflow
   );

   modport slave (
      input  in_valid, input1, input2, sub, out_ready,
      output in_ready, out_valid, answer, carry_out, overflow
   );
endinterface

// File: rtl/pipelined_adder_chunk.sv
// W-bit ripple-carry adder slice; also exposes the carry into its top bit
// so the final slice can form signed overflow.
module adder_chunk #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout,
   output logic         c_msb_in
);

   logic w_c;

   always_comb begin
      s        = '0;
      c_msb_in = 1'b0;
      w_c      = cin;
      for (int i = 0; i < W; i++) begin
         if (i == W - 1) c_msb_in = w_c;
         s[i] = a[i] ^ b[i] ^ w_c;
         w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
      end
      cout = w_c;
   end

endmodule

// File: rtl/pipelined_adder.sv
// N-bit add/subtract split into STAGES carry-pipelined chunks with a
// valid/ready handshake; the last stage register is the output register.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int N      = 8,
   parameter int STAGES = 2
) (
   input logic             clk,
   input logic             reset,
   pipelined_adder_if.slave bus
);

   localparam int W    = chunk_width(N, STAGES);
   localparam int LAST = STAGES - 1;
   localparam logic [N-1:0] CHUNK_MASK = (N'(1) << W) - N'(1);

   logic         w_en;
   logic         w_vin   [STAGES];
   logic [N-1:0] w_a     [STAGES];
   logic [N-1:0] w_b     [STAGES];
   logic [N-1:0] w_sin   [STAGES];
   logic [N-1:0] w_snext [STAGES];
   logic         w_cin   [STAGES];
   logic [W-1:0] w_chunk [STAGES];
   logic         w_cout  [STAGES];
   logic         w_msb   [STAGES];

   logic         r_vld [STAGES];
   logic [N-1:0] r_a   [STAGES];
   logic [N-1:0] r_b   [STAGES];
   logic [N-1:0] r_s   [STAGES];
   logic         r_c   [STAGES];
   logic         r_ovf;

   // The whole pipeline moves as one; a full output register blocks everything.
   assign w_en         = !r_vld[LAST] || bus.out_ready;
   assign bus.in_ready = w_en;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         // Subtraction enters as input1 + ~input2 with carry-in 1.
         assign w_vin[k] = bus.in_valid;
         assign w_a[k]   = bus.input1;
         assign w_b[k]   = (mode_e'(bus.sub) == MODE_SUB) ? ~bus.input2 : bus.input2;
         assign w_sin[k] = '0;
         assign w_cin[k] = bus.sub;
      end else begin : g_next
         assign w_vin[k] = r_vld[k-1];
         assign w_a[k]   = r_a[k-1];
         assign w_b[k]   = r_b[k-1];
         assign w_sin[k] = r_s[k-1];
         assign w_cin[k] = r_c[k-1];
      end

      adder_chunk #(
         .W(W)
      ) u_chunk (
         .a       (w_a[k][k*W +: W]),
         .b       (w_b[k][k*W +: W]),
         .cin     (w_cin[k]),
         .s       (w_chunk[k]),
         .cout    (w_cout[k]),
         .c_msb_in(w_msb[k])
      );

      assign w_snext[k] = (w_sin[k] & ~(CHUNK_MASK << (k*W))) |
                          (N'(w_chunk[k]) << (k*W));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            r_vld[k] <= 1'b0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_s[k]   <= '0;
            r_c[k]   <= 1'b0;
         end
         r_ovf <= 1'b0;
      end else if (w_en) begin
         for (int k = 0; k < STAGES; k++) begin
            r_vld[k] <= w_vin[k];
            r_a[k]   <= w_a[k];
            r_b[k]   <= w_b[k];
            r_s[k]   <= w_snext[k];
            r_c[k]   <= w_cout[k];
         end
         r_ovf <= w_cout[LAST] ^ w_msb[LAST];
      end
   end

   assign bus.out_valid = r_vld[LAST];
   assign bus.answer    = r_s[LAST];
   assign bus.carry_out = r_c[LAST];
   assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vector table and handshake corner
// sequences on an 8-bit/2-stage instance, then random traffic on 1/2/4/8 stages.
module tb_pipelined_adder;

   logic clk = 1'b0;
   logic reset;
   logic rand_en   = 1'b0;
   logic drain_chk = 1'b0;
   int   n_checks  = 0;
   int   n_fail    = 0;

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] ans;
      logic       c;
      logic       v;
   } res_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       s;
      res_t       e;
   } vec_t;

   // Reference: plain integer arithmetic, unsigned for answer/carry and signed for overflow.
   function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
      int   ua, ub, u, sa, sb, r;
      res_t m;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      u  = s ? ua - ub : ua + ub;
      r  = s ? sa - sb : sa + sb;
      m.ans = 8'(u & 255);
      m.c   = s ? (ua >= ub) : (u > 255);
      m.v   = (r > 127) || (r < -128);
      return m;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
      end
   endtask

   pipelined_adder_if #(.N(8)) bus ();

   pipelined_adder #(
      .N     (8),
      .STAGES(2)
   ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // Random traffic instances, one per legal depth for N=8.
   for (genvar gi = 0; gi < 4; gi++) begin : g_rand
      localparam int S = 1 << gi;
      pipelined_adder_if #(.N(8)) rb ();
      pipelined_adder #(
         .N     (8),
         .STAGES(S)
      ) u_r (
         .clk  (clk),
         .reset(reset),
         .bus  (rb)
      );
      res_t exp_q[$];
      int   n_out = 0;

      always @(negedge clk) begin
         if (rand_en) begin
            rb.in_valid  = ($urandom_range(0, 2) != 0);
            rb.out_ready = ($urandom_range(0, 3) != 0);
            rb.input1    = 8'($urandom);
            rb.input2    = 8'($urandom);
            rb.sub       = ($urandom_range(0, 1) == 1);
         end else begin
            rb.in_valid  = 1'b0;
            rb.out_ready = 1'b1;
            rb.input1    = 8'h00;
            rb.input2    = 8'h00;
            rb.sub       = 1'b0;
         end
         #1;
         if (reset === 1'b0) begin
            if (rb.in_valid && rb.in_ready)
               exp_q.push_back(model(rb.input1, rb.input2, rb.sub));
            if (rb.out_valid && rb.out_ready) begin
               n_out++;
               if (exp_q.size() == 0) begin
                  check($sformatf("rand_s%0d_spurious", S), 32'd1, 32'd0);
               end else begin
                  check($sformatf("rand_s%0d_result", S),
                        {rb.answer, rb.carry_out, rb.overflow}, exp_q.pop_front());
               end
            end
         end
      end

      always @(posedge drain_chk) begin
         check($sformatf("rand_s%0d_drained", S), exp_q.size(), 0);
         check($sformatf("rand_s%0d_traffic", S), (n_out > 100), 1);
      end
   end

   task automatic do_one(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input res_t e);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.input1    = a;
      bus.input2    = b;
      bus.sub       = s;
      bus.out_ready = 1'b1;
      #1 check({nm, "_in_ready"}, bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 check({nm, "_latency"}, bus.out_valid, 0);
      @(negedge clk);
      #1 check({nm, "_out_valid"}, bus.out_valid, 1);
      check({nm, "_result"}, {bus.answer, bus.carry_out, bus.overflow}, e);
   endtask

   vec_t tbl[9];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] sa_vals[4];
      logic [7:0] exp_vals[4];
      logic [7:0] held;
      int  in_idx, o_idx, stall_left, cyc;
      bit  seen;

      tbl[0] = '{8'h7F, 8'h01, 1'b0, {8'h80, 1'b0, 1'b1}};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, {8'h00, 1'b1, 1'b0}};
      tbl[2] = '{8'h05, 8'h07, 1'b1, {8'hFE, 1'b0, 1'b0}};
      tbl[3] = '{8'h80, 8'h01, 1'b1, {8'h7F, 1'b1, 1'b1}};
      tbl[4] = '{8'h0F, 8'h01, 1'b0, {8'h10, 1'b0, 1'b0}};
      tbl[5] = '{8'h80, 8'h80, 1'b0, {8'h00, 1'b1, 1'b1}};
      tbl[6] = '{8'h00, 8'h00, 1'b1, {8'h00, 1'b1, 1'b0}};
      tbl[7] = '{8'h7F, 8'hFF, 1'b1, {8'h80, 1'b0, 1'b1}};
      tbl[8] = '{8'h00, 8'h01, 1'b1, {8'hFF, 1'b0, 1'b0}};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.input1    = 8'h00;
      bus.input2    = 8'h00;
      bus.sub       = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_outputs", {bus.answer, bus.carry_out, bus.overflow}, 0);
      reset = 1'b0;
      #1 check("post_rst_in_ready", bus.in_ready, 1);

      // One transaction at a time: exact latency and result.
      for (int i = 0; i < 9; i++)
         do_one($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].e);

      // Same table streamed back to back at full rate.
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         bus.out_ready = 1'b1;
         bus.in_valid  = (i < 9);
         if (i < 9) begin
            bus.input1 = tbl[i].a;
            bus.input2 = tbl[i].b;
            bus.sub    = tbl[i].s;
         end
         #1;
         if (i >= 2) begin
            check($sformatf("stream%0d_valid", i - 2), bus.out_valid, 1);
            check($sformatf("stream%0d_result", i - 2),
                  {bus.answer, bus.carry_out, bus.overflow}, tbl[i - 2].e);
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 check("stream_bubble", bus.out_valid, 0);

      // Four adds with the consumer stalling 3 cycles after the first result.
      for (int i = 0; i < 4; i++) begin
         sa_vals[i]  = 8'(16 * (i + 1));
         exp_vals[i] = 8'(17 * (i + 1));
      end
      in_idx = 0; o_idx = 0; stall_left = 0; seen = 1'b0; held = 8'h00;
      for (cyc = 0; cyc < 20 && o_idx < 4; cyc++) begin
         @(negedge clk);
         if (!seen && bus.out_valid) begin
            seen       = 1'b1;
            stall_left = 3;
            held       = bus.answer;
         end
         bus.out_ready = (stall_left == 0);
         bus.in_valid  = (in_idx < 4);
         if (in_idx < 4) begin
            bus.input1 = sa_vals[in_idx];
            bus.input2 = 8'(in_idx + 1);
            bus.sub    = 1'b0;
         end
         #1;
         if (stall_left > 0) begin
            check($sformatf("stall%0d_in_ready", stall_left), bus.in_ready, 0);
            check($sformatf("stall%0d_out_valid", stall_left), bus.out_valid, 1);
            check($sformatf("stall%0d_stable", stall_left), bus.answer, held);
            stall_left--;
         end
         if (bus.in_valid && bus.in_ready) in_idx++;
         if (bus.out_valid && bus.out_ready) begin
            check($sformatf("stall_order%0d", o_idx), bus.answer, exp_vals[o_idx]);
            o_idx++;
         end
      end
      check("stall_all_delivered", o_idx, 4);
      check("stall_was_seen", seen, 1);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;

      // Reset with two transactions in flight.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.input1   = 8'h21;
      bus.input2   = 8'h01;
      bus.sub      = 1'b0;
      @(negedge clk);
      bus.input1 = 8'h42;
      bus.input2 = 8'h02;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #1 check("inflight_valid", bus.out_valid, 1);
      check("inflight_answer", bus.answer, 8'h22);
      #1 reset = 1'b1;
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_outputs", {bus.answer, bus.carry_out, bus.overflow}, 0);
      @(negedge clk);
      reset         = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1 check($sformatf("postrst_no_stale%0d", i), bus.out_valid, 0);
      end
      do_one("postrst_add", 8'h01, 8'h01, 1'b0, {8'h02, 1'b0, 1'b0});

      // Random traffic on all depths.
      @(negedge clk);
      rand_en = 1'b1;
      repeat (2000) @(negedge clk);
      rand_en = 1'b0;
      repeat (40) @(negedge clk);
      drain_chk = 1'b1;
      #2;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
